// File: rtl/blaze_debug_iface.sv
// Command/response bridge between the MicroBlaze GPIO frames and the MIPS pipeline:
// decodes toggle-handshaked command frames and drives pipeline control, imem load and debug readback.
module blaze_debug_iface #(
    parameter int NB_FRAME   = 32,
    parameter int NB_INSTR   = 32,
    parameter int N_ADDR     = 512,
    parameter int NB_ADDR    = 9,
    parameter int NB_DBG_SEL = 8,
    parameter int NB_CYCLE   = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_FRAME-1:0]   i_frame_from_blaze,
    output logic [NB_FRAME-1:0]   o_frame_to_blaze,
    output logic                  o_pipe_valid,
    output logic                  o_pipe_reset,
    output logic                  o_imem_we,
    output logic [NB_ADDR-1:0]    o_imem_addr,
    output logic [NB_INSTR-1:0]   o_imem_data,
    output logic [NB_DBG_SEL-1:0] o_dbg_sel,
    input  logic [31:0]           i_dbg_data,
    input  logic                  i_halt
);

    // state    | meaning
    // IDLE     | waiting for the synced request toggle to differ from the previous one
    // CAPTURE  | latch command and payload, remember the toggle
    // EXEC     | perform the command action, stage error/data
    // RST_HOLD | hold the pipeline reset for RST_CYCLES cycles (PIPE_RST only)
    // ACK      | flip the ack toggle, publish error/data
    typedef enum logic [2:0] {ST_IDLE, ST_CAPTURE, ST_EXEC, ST_RST_HOLD, ST_ACK} state_t;

    localparam logic [3:0] CMD_NOP      = 4'h0;
    localparam logic [3:0] CMD_SET_ADDR = 4'h1;
    localparam logic [3:0] CMD_WR_LO    = 4'h2;
    localparam logic [3:0] CMD_WR_HI    = 4'h3;
    localparam logic [3:0] CMD_RUN      = 4'h4;
    localparam logic [3:0] CMD_STEP     = 4'h5;
    localparam logic [3:0] CMD_STOP     = 4'h6;
    localparam logic [3:0] CMD_SEL      = 4'h7;
    localparam logic [3:0] CMD_RD_LO    = 4'h8;
    localparam logic [3:0] CMD_RD_HI    = 4'h9;
    localparam logic [3:0] CMD_CYC_LO   = 4'hA;
    localparam logic [3:0] CMD_CYC_HI   = 4'hB;
    localparam logic [3:0] CMD_PIPE_RST = 4'hC;

    localparam int NB_RST = $clog2(RST_CYCLES) + 1;

    state_t                state, state_next;
    logic                  tog_sync1, tog_sync2, tog_prev, ack_tog;
    logic                  running, halted, err, pend_err, cmd_err;
    logic                  step_q, we_q, rst_q;
    logic [NB_RST-1:0]     rst_cnt;
    logic [3:0]            cmd_q;
    logic [15:0]           payload_q, data, pend_data, instr_buf;
    logic [NB_CYCLE-1:0]   cyc_cnt;
    logic [NB_ADDR-1:0]    imem_addr;
    logic [NB_INSTR-1:0]   imem_data;
    logic [NB_DBG_SEL-1:0] dbg_sel;
    logic                  req_det;
    logic                  frame_unused;

    assign frame_unused = ^i_frame_from_blaze[26:16];
    assign req_det      = tog_sync2 != tog_prev;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (req_det) state_next = ST_CAPTURE;
            ST_CAPTURE:  state_next = ST_EXEC;
            ST_EXEC:     state_next = (cmd_q == CMD_PIPE_RST) ? ST_RST_HOLD : ST_ACK;
            ST_RST_HOLD: if (rst_cnt == '0) state_next = ST_ACK;
            ST_ACK:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Rejected commands still ack, but must leave every side effect untouched.
    always_comb begin
        cmd_err = 1'b0;
        case (cmd_q)
            CMD_WR_HI:                                 cmd_err = running;
            CMD_RUN, CMD_STEP:                         cmd_err = running | halted;
            CMD_NOP, CMD_SET_ADDR, CMD_WR_LO, CMD_STOP,
            CMD_SEL, CMD_RD_LO, CMD_RD_HI, CMD_CYC_LO,
            CMD_CYC_HI, CMD_PIPE_RST:                  cmd_err = 1'b0;
            default:                                   cmd_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tog_sync1 <= 1'b0;
            tog_sync2 <= 1'b0;
            tog_prev  <= 1'b0;
            ack_tog   <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
            pend_err  <= 1'b0;
            step_q    <= 1'b0;
            we_q      <= 1'b0;
            rst_q     <= 1'b0;
            rst_cnt   <= '0;
            cmd_q     <= '0;
            payload_q <= '0;
            data      <= '0;
            pend_data <= '0;
            instr_buf <= '0;
            cyc_cnt   <= '0;
            imem_addr <= '0;
            imem_data <= '0;
            dbg_sel   <= '0;
        end else begin
            tog_sync1 <= i_frame_from_blaze[27];
            tog_sync2 <= tog_sync1;
            step_q    <= 1'b0;
            we_q      <= 1'b0;
            if (we_q) begin
                if (imem_addr == NB_ADDR'(N_ADDR - 1)) imem_addr <= '0;
                else                                   imem_addr <= imem_addr + NB_ADDR'(1);
            end
            if (o_pipe_valid && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + NB_CYCLE'(1);
            if (running && i_halt) begin
                running <= 1'b0;
                halted  <= 1'b1;
            end
            case (state)
                ST_CAPTURE: begin
                    cmd_q     <= i_frame_from_blaze[31:28];
                    payload_q <= i_frame_from_blaze[15:0];
                    tog_prev  <= tog_sync2;
                end
                ST_EXEC: begin
                    pend_err  <= cmd_err;
                    pend_data <= data;
                    if (!cmd_err) begin
                        case (cmd_q)
                            CMD_SET_ADDR: imem_addr <= payload_q[NB_ADDR-1:0];
                            CMD_WR_LO:    instr_buf <= payload_q;
                            CMD_WR_HI: begin
                                imem_data <= {payload_q, instr_buf};
                                we_q      <= 1'b1;
                            end
                            CMD_RUN:      running   <= 1'b1;
                            CMD_STEP:     step_q    <= 1'b1;
                            CMD_STOP:     running   <= 1'b0;
                            CMD_SEL:      dbg_sel   <= payload_q[NB_DBG_SEL-1:0];
                            CMD_RD_LO:    pend_data <= i_dbg_data[15:0];
                            CMD_RD_HI:    pend_data <= i_dbg_data[31:16];
                            CMD_CYC_LO:   pend_data <= cyc_cnt[15:0];
                            CMD_CYC_HI:   pend_data <= cyc_cnt[31:16];
                            CMD_PIPE_RST: begin
                                rst_q   <= 1'b1;
                                rst_cnt <= NB_RST'(RST_CYCLES - 1);
                                running <= 1'b0;
                                halted  <= 1'b0;
                                cyc_cnt <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RST_HOLD: begin
                    if (rst_cnt == '0) rst_q   <= 1'b0;
                    else               rst_cnt <= rst_cnt - NB_RST'(1);
                end
                ST_ACK: begin
                    ack_tog <= ~ack_tog;
                    err     <= pend_err;
                    data    <= pend_data;
                end
                default: ;
            endcase
        end
    end

    assign o_frame_to_blaze = {ack_tog, running, halted, err, {(NB_FRAME-20){1'b0}}, data};
    assign o_pipe_valid     = running | step_q;
    assign o_pipe_reset     = rst_q;
    assign o_imem_we        = we_q;
    assign o_imem_addr      = imem_addr;
    assign o_imem_data      = imem_data;
    assign o_dbg_sel        = dbg_sel;

endmodule
